// File: rtl/ber_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ber_pkg
//  Description : Shared types, default widths and saturating-add helper for
//                the BER accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ber_pkg;

    localparam int c_DEF_WIDTH = 8;
    localparam int c_DEF_CNT_W = 48;
    localparam int c_DEF_WIN_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    typedef struct packed {
        logic [63:0] sum;
        logic        carry;
    } sat_res_t;

    // Sum computed one bit wider so a clip against any limit up to 64 bits is exact.
    function automatic sat_res_t sat_add(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input logic [63:0] lim);
        sat_res_t   res;
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (full > {1'b0, lim}) begin
            res.sum   = lim;
            res.carry = 1'b1;
        end else begin
            res.sum   = full[63:0];
            res.carry = 1'b0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ber_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : ber_accumulator_if
//  Description : Checker-side inputs, host controls and status/total outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ber_accumulator_if
    import ber_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CNT_W = c_DEF_CNT_W,
    parameter int WIN_W = c_DEF_WIN_W
);
    logic             en;
    logic             lock;
    logic [WIDTH:0]   err_num;
    logic             start;
    logic             stop;
    logic [WIN_W-1:0] window_words;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;
    logic             done;
    logic             lock_lost;
    logic             overflow;

    modport master (
        output en, lock, err_num, start, stop, window_words,
        input  bit_cnt, err_cnt, busy, done, lock_lost, overflow
    );

    modport slave (
        input  en, lock, err_num, start, stop, window_words,
        output bit_cnt, err_cnt, busy, done, lock_lost, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sat_accum.sv
`default_nettype none
// ============================================================================
//  Module      : sat_accum
//  Description : Saturating accumulator with synchronous clear; o_sat flags a
//                clipped addition in the current cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_accum
    import ber_pkg::*;
#(
    parameter int CNT_W = c_DEF_CNT_W,
    parameter int ADD_W = c_DEF_WIDTH + 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_clr,
    input  wire logic             i_add_en,
    input  wire logic [ADD_W-1:0] i_addend,
    output logic      [CNT_W-1:0] o_value,
    output logic                  o_sat
);
    localparam logic [63:0] c_LIMIT = 64'((65'd1 << CNT_W) - 65'd1);

    logic [CNT_W-1:0] r_value;
    sat_res_t         w_res;

    assign w_res   = sat_add(64'(r_value), 64'(i_addend), c_LIMIT);
    assign o_sat   = i_add_en & w_res.carry;
    assign o_value = r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_add_en) begin
            r_value <= w_res.sum[CNT_W-1:0];
        end
    end

    // Bits above the accumulator width are always zero after the clip.
    generate
        if (CNT_W < 64) begin : g_pad
            logic w_unused_hi;
            assign w_unused_hi = ^w_res.sum[63:CNT_W];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ber_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : ber_accumulator
//  Description : Windowed bit/error accumulation behind prbs_checker, with
//                frozen totals and sticky lock-loss / overflow status.
//  Revision    : 1.0 - initial release
// ============================================================================
module ber_accumulator
    import ber_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int CNT_W = c_DEF_CNT_W,
    parameter int WIN_W = c_DEF_WIN_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ber_accumulator_if.slave bus
);
    localparam logic [31:0] c_BITS_PER_WORD = 32'(WIDTH);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_lock_lost;
    logic             r_overflow;
    logic [WIN_W-1:0] r_words;
    logic [WIN_W-1:0] r_window;

    logic             w_qualify;
    logic [WIN_W-1:0] w_words_inc;
    logic             w_window_hit;
    logic             w_sat_bits;
    logic             w_sat_errs;
    logic [CNT_W-1:0] w_bit_cnt;
    logic [CNT_W-1:0] w_err_cnt;

    assign w_qualify    = (r_state == MEASURE) && bus.en && bus.lock;
    assign w_words_inc  = r_words + WIN_W'(1);
    assign w_window_hit = (r_window != '0) && (w_words_inc == r_window);

    sat_accum #(
        .CNT_W (CNT_W),
        .ADD_W (32)
    ) u_bits (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (bus.start),
        .i_add_en (w_qualify),
        .i_addend (c_BITS_PER_WORD),
        .o_value  (w_bit_cnt),
        .o_sat    (w_sat_bits)
    );

    sat_accum #(
        .CNT_W (CNT_W),
        .ADD_W (WIDTH + 1)
    ) u_errs (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (bus.start),
        .i_add_en (w_qualify),
        .i_addend (bus.err_num),
        .o_value  (w_err_cnt),
        .o_sat    (w_sat_errs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_overflow  <= 1'b0;
            r_words     <= '0;
            r_window    <= '0;
        end else if (bus.start) begin
            // start outranks stop and restarts from any state
            r_state     <= WAIT_LOCK;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_overflow  <= 1'b0;
            r_words     <= '0;
            r_window    <= bus.window_words;
        end else begin
            if (w_sat_bits || w_sat_errs) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
                WAIT_LOCK: begin
                    if (bus.stop) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (bus.lock) begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_qualify) begin
                        r_words <= w_words_inc;
                    end
                    // A lock-loss word is never qualifying, so it cannot also end the window.
                    if (bus.en && !bus.lock) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_lock_lost <= 1'b1;
                    end else if ((w_qualify && w_window_hit) || bus.stop) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bit_cnt   = w_bit_cnt;
    assign bus.err_cnt   = w_err_cnt;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.lock_lost = r_lock_lost;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ber_accumulator.sv
`default_nettype none
// Bench for ber_accumulator: two instances (48-bit and 8-bit accumulators) share
// stimulus and are checked every cycle against an arithmetic model of the rules.
module tb_ber_accumulator;

    localparam int W     = 8;
    localparam int WIN   = 32;
    localparam int CNT_A = 48;
    localparam int CNT_B = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           lock;
    logic [W:0]     err_num;
    logic           start;
    logic           stop;
    logic [WIN-1:0] window_words;

    always #5 clk = ~clk;

    ber_accumulator_if #(.WIDTH(W), .CNT_W(CNT_A), .WIN_W(WIN)) if_a ();
    ber_accumulator_if #(.WIDTH(W), .CNT_W(CNT_B), .WIN_W(WIN)) if_b ();

    assign if_a.en = en;           assign if_b.en = en;
    assign if_a.lock = lock;       assign if_b.lock = lock;
    assign if_a.err_num = err_num; assign if_b.err_num = err_num;
    assign if_a.start = start;     assign if_b.start = start;
    assign if_a.stop = stop;       assign if_b.stop = stop;
    assign if_a.window_words = window_words;
    assign if_b.window_words = window_words;

    ber_accumulator #(.WIDTH(W), .CNT_W(CNT_A), .WIN_W(WIN)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a));
    ber_accumulator #(.WIDTH(W), .CNT_W(CNT_B), .WIN_W(WIN)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b));

    // Model: 0=idle 1=waiting for lock 2=measuring 3=done; totals kept unclipped.
    int              m_state;
    longint unsigned m_bits;
    longint unsigned m_errs;
    bit              m_lost;
    int unsigned     m_words;
    int unsigned     m_win;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic longint unsigned lim(int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint unsigned clip(longint unsigned v, int w);
        return (v > lim(w)) ? lim(w) : v;
    endfunction

    task automatic clear_model();
        m_bits = 0; m_errs = 0; m_lost = 0; m_words = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            m_state = 0; clear_model(); m_win = 0;
        end else if (start) begin
            m_state = 1; clear_model(); m_win = window_words;
        end else if (m_state == 1) begin
            if (stop) m_state = 3;
            else if (lock) m_state = 2;
        end else if (m_state == 2) begin
            if (en && !lock) begin
                m_lost = 1; m_state = 3;
            end else begin
                if (en) begin
                    m_bits += W; m_errs += err_num; m_words++;
                end
                if (en && m_win != 0 && m_words == m_win) m_state = 3;
                else if (stop) m_state = 3;
            end
        end
    endtask

    task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cmp("a.bit_cnt",   if_a.bit_cnt,   clip(m_bits, CNT_A));
        cmp("a.err_cnt",   if_a.err_cnt,   clip(m_errs, CNT_A));
        cmp("a.busy",      if_a.busy,      (m_state == 1 || m_state == 2));
        cmp("a.done",      if_a.done,      (m_state == 3));
        cmp("a.lock_lost", if_a.lock_lost, m_lost);
        cmp("a.overflow",  if_a.overflow,  (m_bits > lim(CNT_A) || m_errs > lim(CNT_A)));
        cmp("b.bit_cnt",   if_b.bit_cnt,   clip(m_bits, CNT_B));
        cmp("b.err_cnt",   if_b.err_cnt,   clip(m_errs, CNT_B));
        cmp("b.busy",      if_b.busy,      (m_state == 1 || m_state == 2));
        cmp("b.done",      if_b.done,      (m_state == 3));
        cmp("b.lock_lost", if_b.lock_lost, m_lost);
        cmp("b.overflow",  if_b.overflow,  (m_bits > lim(CNT_B) || m_errs > lim(CNT_B)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Pulses start with the given window; the caller decides lock/en for the next cycle.
    task automatic arm(int unsigned win);
        window_words = win; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; lock = 1'b0; err_num = '0;
        start = 1'b0; stop = 1'b0; window_words = '0;
        m_state = 0; m_win = 0; clear_model();
        @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset in the middle of a measurement
        en = 1'b1; lock = 1'b1;
        arm(100);
        tick();
        repeat (40) tick();
        cmp("mid.bit_cnt_before_reset", if_a.bit_cnt, 320);
        reset = 1'b1; tick(); reset = 1'b0;
        cmp("mid.bit_cnt_after_reset", if_a.bit_cnt, 0);
        cmp("mid.busy_after_reset", if_a.busy, 0);
        repeat (10) tick();

        // error-free window of 1000 words
        err_num = '0;
        arm(1000);
        tick();
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i == 998) cmp("win1000.done_early", if_a.done, 0);
        end
        cmp("win1000.done", if_a.done, 1);
        cmp("win1000.bit_cnt", if_a.bit_cnt, 8000);
        cmp("win1000.err_cnt", if_a.err_cnt, 0);
        cmp("win1000.lock_lost", if_a.lock_lost, 0);
        tick();
        cmp("win1000.frozen", if_a.bit_cnt, 8000);

        // error tally with a five-cycle stall
        arm(10);
        tick();
        for (int w = 1; w <= 10; w++) begin
            err_num = (w == 3 || w == 7) ? 9'd1 : ((w == 9) ? 9'd8 : 9'd0);
            tick();
            if (w == 5) begin
                en = 1'b0; err_num = 9'd5;
                repeat (5) tick();
                cmp("stall.bit_cnt_hold", if_a.bit_cnt, 40);
                en = 1'b1;
            end
        end
        err_num = '0;
        cmp("tally.bit_cnt", if_a.bit_cnt, 80);
        cmp("tally.err_cnt", if_a.err_cnt, 10);
        cmp("tally.done", if_a.done, 1);

        // lock loss after 20 words
        arm(50);
        tick();
        repeat (20) tick();
        lock = 1'b0; tick(); lock = 1'b1;
        cmp("lockloss.lock_lost", if_a.lock_lost, 1);
        cmp("lockloss.bit_cnt", if_a.bit_cnt, 160);
        cmp("lockloss.done", if_a.done, 1);

        // free run, stop on a qualifying word, then restart with start+stop
        arm(0);
        tick();
        repeat (300) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        cmp("freerun.bit_cnt", if_a.bit_cnt, 2408);
        cmp("freerun.done", if_a.done, 1);
        window_words = 5; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        cmp("startstop.busy", if_a.busy, 1);
        cmp("startstop.bit_cnt", if_a.bit_cnt, 0);
        stop = 1'b1; tick(); stop = 1'b0;
        cmp("waitstop.done", if_a.done, 1);

        // saturation of the 8-bit instance
        err_num = 9'd8;
        arm(40);
        tick();
        repeat (40) tick();
        cmp("sat.b_err_cnt", if_b.err_cnt, 255);
        cmp("sat.b_bit_cnt", if_b.bit_cnt, 255);
        cmp("sat.b_overflow", if_b.overflow, 1);
        cmp("sat.a_err_cnt", if_a.err_cnt, 320);
        arm(40);
        cmp("sat.b_overflow_cleared", if_b.overflow, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 149) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            if (start)
                window_words = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 60));
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 39) == 0) lock = ~lock;
            err_num = 9'($urandom_range(0, W));
            tick();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
